host_line_loader: RTL

- Bulk-read stage between the CCI-P/MPF read channel (c0Tx/c0Rx) and the accelerator's local data memory.
- On start, issues num_lines consecutive cache-line reads from a host buffer and writes each returned line into local memory at its line index.
- Responses may return out of order; each one is steered by its mdata tag.
- Signals done when every line has landed. The AFU then pulses the accelerator's start input.

---
 rtl/host_loader_pkg.sv | 21 ++
 rtl/loader_credit_ctr.sv | 35 +++
 rtl/host_line_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/host_loader_pkg.sv
// Shared types for the host line loader: FSM states, line index, request tag helper.
// Pure declarations; no latency. Carries no handshake or backpressure of its own.
package host_loader_pkg;

    localparam int LOADER_MDATA_W = 16;
    localparam int LOADER_IDX_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_loader_state;

    typedef logic [LOADER_IDX_W-1:0] t_line_idx;

    function automatic logic [LOADER_MDATA_W-1:0] idx_to_mdata(input t_line_idx idx);
        return LOADER_MDATA_W'(idx);
    endfunction

endpackage

// File: rtl/loader_credit_ctr.sv
// Outstanding-read counter: up on issue, down on accepted response, both together hold.
// Registered count, has_credit follows one cycle after an inc/dec. Refuses to wrap at 0 or MAX.
module loader_credit_ctr #(
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_has_credit
);

    localparam int                CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  MAX_V = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_count;
    logic             w_inc;
    logic             w_dec;

    assign w_inc = i_inc && (r_count != MAX_V);
    assign w_dec = i_dec && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_has_credit = (r_count < MAX_V);

endmodule

// File: rtl/host_line_loader.sv
// Bulk-loads num_lines host cache lines into local memory, steering out-of-order responses by tag.
// Request 1 cycle after the issue decision; response to memory write exactly 1 cycle.
// Issue stalls on c0_alm_full or when MAX_OUTSTANDING reads are in flight; responses are never stalled.
module host_line_loader
    import host_loader_pkg::*;
#(
    parameter int NUM_LINES_MAX   = 1024,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int IDX_W           = $clog2(NUM_LINES_MAX)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [IDX_W:0]            num_lines,
    output logic                      c0_req_valid,
    output logic [ADDR_W-1:0]         c0_req_addr,
    output logic [LOADER_MDATA_W-1:0] c0_req_mdata,
    input  logic                      c0_alm_full,
    input  logic                      c0_rsp_valid,
    input  logic [LOADER_MDATA_W-1:0] c0_rsp_mdata,
    input  logic [DATA_W-1:0]         c0_rsp_data,
    output logic                      mem_wr_en,
    output logic [IDX_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               spurious_cnt
);

    localparam logic [IDX_W:0] LINES_MAX_V = (IDX_W + 1)'(NUM_LINES_MAX);

    t_loader_state             r_state;
    t_loader_state             w_state_nxt;
    logic [ADDR_W-1:0]         r_base;
    logic [IDX_W:0]            r_n;
    logic [IDX_W:0]            r_issue_idx;
    logic [IDX_W:0]            r_recv_cnt;
    logic                      r_req_vld;
    logic [ADDR_W-1:0]         r_req_addr;
    logic [LOADER_MDATA_W-1:0] r_req_mdata;
    logic                      r_wr_en;
    logic [IDX_W-1:0]          r_wr_addr;
    logic [DATA_W-1:0]         r_wr_data;
    logic                      r_busy;
    logic                      r_done;
    logic [15:0]               r_spurious;

    logic                      w_has_credit;
    logic                      w_start_acc;
    logic                      w_issue;
    logic                      w_rsp_acc;
    logic [IDX_W:0]            w_n_clamped;
    logic [IDX_W:0]            w_issue_idx_inc;
    logic [IDX_W:0]            w_recv_nxt;

    assign w_n_clamped     = (num_lines > LINES_MAX_V) ? LINES_MAX_V : num_lines;
    assign w_start_acc     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_issue         = (r_state == ISSUE) && !c0_alm_full && w_has_credit
                             && (r_issue_idx < r_n);
    assign w_issue_idx_inc = r_issue_idx + 1'b1;
    // Tags at or beyond n cannot belong to this load; n <= NUM_LINES_MAX keeps upper tag bits zero.
    assign w_rsp_acc       = c0_rsp_valid && ((r_state == ISSUE) || (r_state == DRAIN))
                             && (c0_rsp_mdata < LOADER_MDATA_W'(r_n));
    assign w_recv_nxt      = w_rsp_acc ? (r_recv_cnt + 1'b1) : r_recv_cnt;

    loader_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk          (clk),
        .reset        (reset),
        .i_inc        (w_issue),
        .i_dec        (w_rsp_acc),
        .o_has_credit (w_has_credit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = (w_n_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue && (w_issue_idx_inc == r_n)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Evaluated on the next count so done lands with the final write.
                if (w_recv_nxt >= r_n) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_n         <= '0;
            r_issue_idx <= '0;
            r_recv_cnt  <= '0;
            r_req_vld   <= 1'b0;
            r_req_addr  <= '0;
            r_req_mdata <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spurious  <= '0;
        end else begin
            if (w_start_acc) begin
                r_base      <= base_addr;
                r_n         <= w_n_clamped;
                r_issue_idx <= '0;
                r_recv_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_idx <= w_issue_idx_inc;
                end
                r_recv_cnt <= w_recv_nxt;
            end

            r_req_vld <= w_issue;
            if (w_issue) begin
                r_req_addr  <= r_base + ADDR_W'(r_issue_idx);
                r_req_mdata <= idx_to_mdata(r_issue_idx[IDX_W-1:0]);
            end

            r_wr_en <= w_rsp_acc;
            if (w_rsp_acc) begin
                r_wr_addr <= c0_rsp_mdata[IDX_W-1:0];
                r_wr_data <= c0_rsp_data;
            end

            if (c0_rsp_valid && !w_rsp_acc && (r_spurious != 16'hFFFF)) begin
                r_spurious <= r_spurious + 16'd1;
            end

            r_busy <= (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
            r_done <= (w_state_nxt == DONE);
        end
    end

    assign c0_req_valid = r_req_vld;
    assign c0_req_addr  = r_req_addr;
    assign c0_req_mdata = r_req_mdata;
    assign mem_wr_en    = r_wr_en;
    assign mem_wr_addr  = r_wr_addr;
    assign mem_wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign spurious_cnt = r_spurious;

endmodule
